// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared period counter, per-channel double-buffered
// pulse widths, edge-aligned or center-aligned counting.
module pwm_multi #(
  parameter int CNT_W  = 20,
  parameter int CH_NUM = 4,
  parameter int CENTER = 0
) (
  input  logic                    i_sysclk,
  input  logic                    i_arst,
  input  logic                    i_pv,
  input  logic [CNT_W-1:0]        i_period,
  input  logic [CH_NUM*CNT_W-1:0] i_hpw,
  input  logic [CH_NUM-1:0]       i_en,
  input  logic [CH_NUM-1:0]       i_pol,
  output logic                    o_pa,
  output logic [CH_NUM-1:0]       o_pwm
);

  logic [CNT_W-1:0]        cnt_p0;
  logic [CNT_W-1:0]        period_p0;
  logic [CH_NUM*CNT_W-1:0] hpw_p0;
  logic                    down_p0;

  logic [CNT_W-1:0]        cnt_nx;
  logic [CNT_W-1:0]        period_nx;
  logic [CH_NUM*CNT_W-1:0] hpw_nx;
  logic                    down_nx;
  logic                    start_nx;
  logic [CH_NUM-1:0]       pwm_nx;

  logic                    pa_p1;
  logic [CH_NUM-1:0]       pwm_p1;

  logic [CNT_W-1:0]        top;
  logic                    idle;
  logic                    last;
  logic                    boundary;
  logic                    load;

  function automatic logic duty_cmp(input logic [CNT_W-1:0] cnt, input logic [CNT_W-1:0] hpw);
    return cnt < hpw;
  endfunction

  // Outputs are registered from the next-state counter/shadows so that o_pwm and o_pa
  // line up with the counter value they describe, including the first cycle after a load.
  always_comb begin
    top       = period_p0 - CNT_W'(1);
    idle      = (period_p0 == '0);
    if (CENTER != 0) last = !idle && down_p0 && (cnt_p0 == '0);
    else             last = !idle && (cnt_p0 == top);
    boundary  = idle || last;
    load      = boundary && i_pv;
    period_nx = load ? i_period : period_p0;
    hpw_nx    = load ? i_hpw : hpw_p0;
    cnt_nx    = cnt_p0;
    down_nx   = down_p0;
    start_nx  = 1'b0;
    if (boundary) begin
      cnt_nx   = '0;
      down_nx  = 1'b0;
      start_nx = (period_nx != '0);
    end else if (CENTER == 0) begin
      cnt_nx = cnt_p0 + CNT_W'(1);
    end else if (!down_p0) begin
      // The top value is held for a second cycle while the direction flips.
      if (cnt_p0 == top) down_nx = 1'b1;
      else               cnt_nx  = cnt_p0 + CNT_W'(1);
    end else begin
      cnt_nx = cnt_p0 - CNT_W'(1);
    end
    pwm_nx = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      pwm_nx[n] = ((period_nx != '0) && i_en[n] &&
                   duty_cmp(cnt_nx, hpw_nx[n*CNT_W +: CNT_W])) ^ i_pol[n];
    end
  end

  // Stage p0: counter, direction and shadow registers
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      cnt_p0    <= '0;
      period_p0 <= '0;
      hpw_p0    <= '0;
      down_p0   <= 1'b0;
    end else begin
      cnt_p0    <= cnt_nx;
      period_p0 <= period_nx;
      hpw_p0    <= hpw_nx;
      down_p0   <= down_nx;
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      pa_p1  <= 1'b0;
      pwm_p1 <= '0;
    end else begin
      pa_p1  <= start_nx;
      pwm_p1 <= pwm_nx;
    end
  end

  assign o_pa  = pa_p1;
  assign o_pwm = pwm_p1;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: an edge-aligned and a center-aligned instance share
// stimulus; expected {o_pa, o_pwm} per cycle are queued and popped against the outputs.
module tb_pwm_multi;

  localparam int CNT_W  = 20;
  localparam int CH_NUM = 4;

  logic                    clk;
  logic                    rst;
  logic                    pv;
  logic [CNT_W-1:0]        period;
  logic [CH_NUM*CNT_W-1:0] hpw;
  logic [CH_NUM-1:0]       en;
  logic [CH_NUM-1:0]       pol;
  logic                    pa_e;
  logic [CH_NUM-1:0]       pwm_e;
  logic                    pa_c;
  logic [CH_NUM-1:0]       pwm_c;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e;
  logic [4:0] got;

  pwm_multi #(.CNT_W(CNT_W), .CH_NUM(CH_NUM), .CENTER(0)) dut_edge (
    .i_sysclk(clk), .i_arst(rst), .i_pv(pv), .i_period(period), .i_hpw(hpw),
    .i_en(en), .i_pol(pol), .o_pa(pa_e), .o_pwm(pwm_e)
  );

  pwm_multi #(.CNT_W(CNT_W), .CH_NUM(CH_NUM), .CENTER(1)) dut_center (
    .i_sysclk(clk), .i_arst(rst), .i_pv(pv), .i_period(period), .i_hpw(hpw),
    .i_en(en), .i_pol(pol), .o_pa(pa_c), .o_pwm(pwm_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge-aligned expectation for cycle k of a run with period p: {period alert, outputs}.
  function automatic logic [4:0] exp_edge(input int k, input int p, input int h0, input int h1,
                                          input int h2, input int h3, input logic [3:0] en_v,
                                          input logic [3:0] pol_v);
    int c;
    logic [3:0] r;
    c = k % p;
    r[0] = (c < h0);
    r[1] = (c < h1);
    r[2] = (c < h2);
    r[3] = (c < h3);
    return {c == 0, (r & en_v) ^ pol_v};
  endfunction

  task automatic test_reset();
    pol = 4'b1010;
    step();
    checks++;
    if ({pa_e, pwm_e} !== 5'b0) begin
      errors++;
      $display("FAIL reset_edge got=%b required=%b", {pa_e, pwm_e}, 5'b0);
    end
    checks++;
    if ({pa_c, pwm_c} !== 5'b0) begin
      errors++;
      $display("FAIL reset_center got=%b required=%b", {pa_c, pwm_c}, 5'b0);
    end
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 4'b1010});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL idle_after_reset got=%b required=%b", got, e);
      end
      step();
    end
  endtask

  task automatic test_basic();
    pv = 1'b1; period = 4; hpw = {20'd0, 20'd0, 20'd0, 20'd2}; en = 4'b0001; pol = 4'b0000;
    step();
    pv = 1'b0;
    for (int k = 0; k < 12; k++) exp_q.push_back(exp_edge(k, 4, 2, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL basic cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_shadow();
    hpw = {20'd0, 20'd0, 20'd0, 20'd3};
    for (int k = 0; k < 12; k++) exp_q.push_back(exp_edge(k, 4, 2, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL shadow_hold cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
    pv = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_edge(k, 4, 2, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_edge(k, 4, 3, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL shadow_update cyc=%0d got=%b required=%b", k, got, e);
      end
      if (k == 4) pv = 1'b0;
      step();
    end
  endtask

  task automatic test_period_extremes();
    pv = 1'b1; period = 10; hpw = {20'd15, 20'd10, 20'd0, 20'd8}; en = 4'b1111;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_edge(k, 4, 3, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; k < 20; k++) exp_q.push_back(exp_edge(k, 10, 8, 0, 10, 15, 4'b1111, 4'b0000));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL period_extremes cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
    pv = 1'b0;
  endtask

  task automatic test_en_pol();
    for (int k = 0; k < 20; k++) begin
      if (k == 4) begin
        en = 4'b1101; pol = 4'b0010;
      end
      if (k == 7) pol = 4'b0011;
      if (k < 5)      e = exp_edge(k, 10, 8, 0, 10, 15, 4'b1111, 4'b0000);
      else if (k < 8) e = exp_edge(k, 10, 8, 0, 10, 15, 4'b1101, 4'b0010);
      else            e = exp_edge(k, 10, 8, 0, 10, 15, 4'b1101, 4'b0011);
      exp_q.push_back(e);
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL en_pol cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    step(); step(); step();
    rst = 1'b1;
    #1;
    checks++;
    if ({pa_e, pwm_e} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_edge got=%b required=%b", {pa_e, pwm_e}, 5'b0);
    end
    checks++;
    if ({pa_c, pwm_c} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_center got=%b required=%b", {pa_c, pwm_c}, 5'b0);
    end
    #1;
    rst = 1'b0;
    step();
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 4'b0011});
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL idle_after_mid_reset got=%b required=%b", got, e);
      end
      step();
    end
    pv = 1'b1; period = 4; hpw = {20'd0, 20'd0, 20'd0, 20'd2}; en = 4'b0001; pol = 4'b0000;
    step();
    pv = 1'b0;
    for (int k = 0; k < 8; k++) exp_q.push_back(exp_edge(k, 4, 2, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL restart cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_center();
    logic [7:0] pat;
    pat = 8'b1000_0001;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    pv = 1'b1; period = 4; hpw = {20'd0, 20'd0, 20'd0, 20'd1}; en = 4'b0001; pol = 4'b0000;
    step();
    pv = 1'b0;
    for (int k = 0; k < 16; k++) exp_q.push_back({(k % 8) == 0, 3'b000, pat[k % 8]});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_c, pwm_c};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL center cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
  endtask

  task automatic test_p1_to_idle();
    pv = 1'b1; period = 1;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_edge(k, 4, 1, 0, 0, 0, 4'b0001, 4'b0000));
    for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, 4'b0001});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL p1 cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
    period = 0;
    exp_q.push_back({1'b1, 4'b0001});
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, 4'b0000});
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      got = {pa_e, pwm_e};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL back_to_idle cyc=%0d got=%b required=%b", k, got, e);
      end
      step();
    end
    pv = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pv = 1'b0; period = '0; hpw = '0; en = '0; pol = '0;
    step();
    test_reset();
    test_basic();
    test_shadow();
    test_period_extremes();
    test_en_pol();
    test_reset_mid();
    test_center();
    test_p1_to_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
